// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the byte-serial memory port arbiter:
// request size encodings, I/O space decode value and the grant FSM states.
package riscv_mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;

  // addr[17:16] value that selects the UART / memory-mapped I/O window
  localparam logic [1:0] IO_SPACE = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    IF_RD   = 3'd1,
    LS_RD   = 3'd2,
    LS_WR   = 3'd3,
    IO_WAIT = 3'd4
  } arb_state_e;

  // Number of byte cycles for a request. I/O is always a single byte;
  // the illegal size code 3 is treated as a full word.
  function automatic logic [2:0] bytes_for(input logic [1:0] size, input logic is_io);
    logic [2:0] n;
    if (is_io) begin
      n = 3'd1;
    end else begin
      case (size)
        SZ_BYTE: n = 3'd1;
        SZ_HALF: n = 3'd2;
        SZ_WORD: n = 3'd4;
        default: n = 3'd4;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte sequencer for the shared memory port: keeps the byte counter and the
// latched base address, extracts the outgoing write byte, and assembles read
// bytes little-endian. A read byte is captured the cycle after its address
// was issued, independent of rdy, so a stall never loses a returning byte.
module mem_byte_seq
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [31:0]       start_data,
  input  logic              issue,
  input  logic              issue_rd,
  input  logic [7:0]        mem_din,
  output logic [2:0]        cnt,
  output logic [ADDR_W-1:0] cur_addr,
  output logic [7:0]        cur_byte,
  output logic [31:0]       data_next
);

  logic [2:0]        cnt_q, cnt_d;
  logic              cap_vld_q, cap_vld_d;
  logic [1:0]        cap_idx_q, cap_idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       data_q, data_d;

  // Merge any returning read byte, then advance or reload the sequence
  always_comb begin
    data_next = data_q;
    if (cap_vld_q) begin
      data_next[{cap_idx_q, 3'b000} +: 8] = mem_din;
    end
    cnt_d     = cnt_q;
    base_d    = base_q;
    data_d    = data_next;
    cap_vld_d = issue && issue_rd;
    cap_idx_d = cnt_q[1:0];
    if (start) begin
      cnt_d     = 3'd0;
      base_d    = start_addr;
      data_d    = start_data;
      cap_vld_d = 1'b0;
    end else if (issue) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  // Control registers: byte counter and pending-capture flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q     <= 3'd0;
      cap_vld_q <= 1'b0;
      cap_idx_q <= 2'd0;
    end else begin
      cnt_q     <= cnt_d;
      cap_vld_q <= cap_vld_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  // Datapath registers: base address and assembly/extraction word
  always_ff @(posedge clk_in) begin
    base_q <= base_d;
    data_q <= data_d;
  end

  assign cnt      = cnt_q;
  assign cur_addr = base_q + ADDR_W'(cnt_q);
  assign cur_byte = data_q[{cnt_q[1:0], 3'b000} +: 8];

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter for the single byte-wide memory/UART port shared by instruction
// fetch and the load/store buffer. Owns the grant FSM; byte sequencing and
// little-endian assembly live in mem_byte_seq.
// Build option: define MEM_ARB_RR_EN for round-robin between contested
// requesters; otherwise the LSB always wins a contested arbitration.
module mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IO_GAP = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  localparam logic       HAS_GAP  = (IO_GAP > 0);
  localparam logic [7:0] GAP_LAST = 8'((IO_GAP > 0) ? IO_GAP - 1 : 0);

  arb_state_e state_q, state_d;

  logic [2:0]  nbytes_q, nbytes_d;
  logic        is_io_q, is_io_d;
  logic [7:0]  gap_q, gap_d;
  logic        if_done_q, if_done_d;
  logic        lsb_done_q, lsb_done_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] lsb_rdata_q, lsb_rdata_d;

  logic [2:0]        seq_cnt;
  logic [ADDR_W-1:0] seq_addr;
  logic [7:0]        seq_byte;
  logic [31:0]       seq_data;

  logic              lsb_prio;
  logic              lsb_is_io;
  logic              grant_lsb;
  logic              accept;
  logic              rd_active;
  logic              rd_issue;
  logic              wr_issue;
  logic              last_byte;
  logic              rd_finish;
  logic              wr_finish;
  logic [ADDR_W-1:0] start_addr;
  logic [31:0]       start_data;

`ifdef MEM_ARB_RR_EN
  logic last_if_q, last_if_d;

  // Remember who was granted last so the other side wins the next contest
  always_comb begin
    last_if_d = last_if_q;
    if (accept) begin
      last_if_d = !grant_lsb;
    end
  end

  // Reset as if IF was served last, so the first contest matches fixed priority
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_if_q <= 1'b1;
    end else begin
      last_if_q <= last_if_d;
    end
  end

  assign lsb_prio = last_if_q;
`else
  assign lsb_prio = 1'b1;
`endif

  // Request decode: arbitration, byte issue and transfer completion
  always_comb begin
    lsb_is_io = (lsb_addr[17:16] == IO_SPACE);
    grant_lsb = lsb_req && (!if_req || lsb_prio);
    // The done cycle still sees the old request held high, so no grant then.
    accept    = (state_q == IDLE) && rdy_in && !(if_done_q || lsb_done_q)
                && (lsb_req || if_req);
    rd_active = (state_q == IF_RD) || (state_q == LS_RD);
    rd_issue  = rdy_in && rd_active && (seq_cnt < nbytes_q);
    wr_issue  = rdy_in && (state_q == LS_WR) && !(is_io_q && io_buffer_full);
    last_byte = (seq_cnt == (nbytes_q - 3'd1));
    // Reads end one cycle after the last address, when its byte returns.
    rd_finish = rdy_in && rd_active && !flush && (seq_cnt == nbytes_q);
    wr_finish = wr_issue && last_byte;
    start_addr = grant_lsb ? lsb_addr : if_addr;
    start_data = (grant_lsb && lsb_wr) ? lsb_wdata : 32'h0;
  end

  mem_byte_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start      (accept),
    .start_addr (start_addr),
    .start_data (start_data),
    .issue      (rd_issue || wr_issue),
    .issue_rd   (rd_issue),
    .mem_din    (mem_din),
    .cnt        (seq_cnt),
    .cur_addr   (seq_addr),
    .cur_byte   (seq_byte),
    .data_next  (seq_data)
  );

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = grant_lsb ? (lsb_wr ? LS_WR : LS_RD) : IF_RD;
        end
      end
      IF_RD, LS_RD: begin
        if (rdy_in && (flush || (seq_cnt == nbytes_q))) begin
          state_d = IDLE;
        end
      end
      LS_WR: begin
        // Stores are already committed, so flush does not stop them.
        if (wr_finish) begin
          state_d = (is_io_q && HAS_GAP) ? IO_WAIT : IDLE;
        end
      end
      IO_WAIT: begin
        if (rdy_in && (gap_q == GAP_LAST)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: drive the port only in an issuing cycle, else read address 0
  always_comb begin
    mem_a    = (rd_issue || wr_issue) ? seq_addr : '0;
    mem_wr   = wr_issue;
    mem_dout = wr_issue ? seq_byte : 8'h00;
  end

  // Transfer bookkeeping, done pulses and result registers
  always_comb begin
    nbytes_d    = nbytes_q;
    is_io_d     = is_io_q;
    gap_d       = gap_q;
    if_done_d   = rd_finish && (state_q == IF_RD);
    lsb_done_d  = (rd_finish && (state_q == LS_RD)) || wr_finish;
    if_data_d   = if_done_d ? seq_data : if_data_q;
    lsb_rdata_d = (rd_finish && (state_q == LS_RD)) ? seq_data : lsb_rdata_q;
    if (accept) begin
      nbytes_d = grant_lsb ? bytes_for(lsb_size, lsb_is_io) : 3'd4;
      is_io_d  = grant_lsb && lsb_is_io;
    end
    if (wr_finish) begin
      gap_d = 8'd0;
    end else if ((state_q == IO_WAIT) && rdy_in) begin
      gap_d = gap_q + 8'd1;
    end
  end

  // Bookkeeping and result registers; results are cleared on reset too
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      nbytes_q    <= 3'd0;
      is_io_q     <= 1'b0;
      gap_q       <= 8'd0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= 32'h0;
      lsb_rdata_q <= 32'h0;
    end else begin
      nbytes_q    <= nbytes_d;
      is_io_q     <= is_io_d;
      gap_q       <= gap_d;
      if_done_q   <= if_done_d;
      lsb_done_q  <= lsb_done_d;
      if_data_q   <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign if_done   = if_done_q;
  assign if_data   = if_data_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch read, contested store then fetch,
// I/O write hold, flush handling, rdy stall and mid-transfer reset.
// Cycle c of a scenario starts 1ns after a rising edge; outputs are sampled
// on the falling edge inside that cycle.
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        lsb_req;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_done;
  logic [31:0] lsb_rdata;
  logic        io_buffer_full;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  logic [7:0]  mem [0:1023];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk_in = ~clk_in;

  // Read byte returns the cycle after its address
  always @(posedge clk_in) mem_din <= mem[mem_a[9:0]];

  mem_arbiter #(.ADDR_W(32), .IO_GAP(1)) dut (
    .clk_in (clk_in), .rst_in (rst_in), .rdy_in (rdy_in), .flush (flush),
    .if_req (if_req), .if_addr (if_addr), .if_done (if_done), .if_data (if_data),
    .lsb_req (lsb_req), .lsb_wr (lsb_wr), .lsb_size (lsb_size), .lsb_addr (lsb_addr),
    .lsb_wdata (lsb_wdata), .lsb_done (lsb_done), .lsb_rdata (lsb_rdata),
    .io_buffer_full (io_buffer_full), .mem_din (mem_din), .mem_dout (mem_dout),
    .mem_a (mem_a), .mem_wr (mem_wr)
  );

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    rdy_in = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    lsb_req = 1'b0; lsb_wr = 1'b0; lsb_size = 2'd0; lsb_addr = 32'h0;
    lsb_wdata = 32'h0; io_buffer_full = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_in = 1'b1;
    next_cycle();
    next_cycle();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_in = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk_in);
    n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    n_checks++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
    n_checks++; if (if_done !== 1'b0 || lsb_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b%b want 00", if_done, lsb_done); end
    n_checks++; if (if_data !== 32'h0 || lsb_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h %h want 0 0", if_data, lsb_rdata); end
    next_cycle();
    rst_in = 1'b0;
  endtask

  task automatic test_if_read();
    logic [31:0] exp_a;
    do_reset();
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 0; c < 8; c++) begin
      if (c == 7) if_req = 1'b0;
      @(negedge clk_in);
      exp_a = (c >= 1 && c <= 4) ? 32'h10 + 32'(c - 1) : 32'h0;
      n_checks++; if (mem_a !== exp_a || mem_wr !== 1'b0) begin n_fail++; $display("FAIL if_read_addr c=%0d: got %h/%b want %h/0", c, mem_a, mem_wr, exp_a); end
      n_checks++; if (if_done !== (c == 6)) begin n_fail++; $display("FAIL if_read_done c=%0d: got %b want %b", c, if_done, (c == 6)); end
      if (c == 6) begin
        n_checks++; if (if_data !== 32'h00000513) begin n_fail++; $display("FAIL if_read_data: got %h want 00000513", if_data); end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a;
    logic        exp_wr;
    logic [31:0] wd;
    do_reset();
    wd = 32'hDEADBEEF;
    if_req = 1'b1; if_addr = 32'h40;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h100; lsb_wdata = wd;
    for (int c = 0; c < 14; c++) begin
      if (c == 6) lsb_req = 1'b0;
      if (c == 13) if_req = 1'b0;
      @(negedge clk_in);
      exp_wr = (c >= 1 && c <= 4);
      exp_a  = exp_wr ? 32'h100 + 32'(c - 1) : (c >= 7 && c <= 10) ? 32'h40 + 32'(c - 7) : 32'h0;
      n_checks++; if (mem_a !== exp_a || mem_wr !== exp_wr) begin n_fail++; $display("FAIL b2b_addr c=%0d: got %h/%b want %h/%b", c, mem_a, mem_wr, exp_a, exp_wr); end
      if (exp_wr) begin
        n_checks++; if (mem_dout !== wd[8*(c-1) +: 8]) begin n_fail++; $display("FAIL b2b_dout c=%0d: got %h want %h", c, mem_dout, wd[8*(c-1) +: 8]); end
      end
      n_checks++; if (lsb_done !== (c == 5) || if_done !== (c == 12)) begin n_fail++; $display("FAIL b2b_done c=%0d: got lsb=%b if=%b", c, lsb_done, if_done); end
      if (c == 12) begin
        n_checks++; if (if_data !== 32'h78563412) begin n_fail++; $display("FAIL b2b_if_data: got %h want 78563412", if_data); end
      end
      next_cycle();
    end
  endtask

  task automatic test_io_write();
    logic [31:0] exp_a;
    int          done_cnt;
    int          wr_cnt;
    do_reset();
    done_cnt = 0;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd0; lsb_addr = 32'h30000; lsb_wdata = 32'h41;
    io_buffer_full = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 4) io_buffer_full = 1'b0;
      if (c == 6) lsb_req = 1'b0;
      @(negedge clk_in);
      exp_a = (c == 4) ? 32'h30000 : 32'h0;
      n_checks++; if (mem_a !== exp_a || mem_wr !== (c == 4)) begin n_fail++; $display("FAIL io_hold c=%0d: got %h/%b want %h/%b", c, mem_a, mem_wr, exp_a, (c == 4)); end
      if (c == 4) begin
        n_checks++; if (mem_dout !== 8'h41) begin n_fail++; $display("FAIL io_dout: got %h want 41", mem_dout); end
      end
      if (lsb_done === 1'b1) done_cnt++;
      next_cycle();
    end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL io_done_count: got %0d want 1", done_cnt); end
    // Word-sized request into I/O space moves a single byte
    wr_cnt = 0;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h30004; lsb_wdata = 32'h11223344;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) lsb_req = 1'b0;
      @(negedge clk_in);
      if (mem_wr === 1'b1) wr_cnt++;
      if (c == 1) begin
        n_checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h30004 || mem_dout !== 8'h44) begin n_fail++; $display("FAIL io_word_byte: got %b %h %h want 1 00030004 44", mem_wr, mem_a, mem_dout); end
      end
      n_checks++; if (lsb_done !== (c == 2)) begin n_fail++; $display("FAIL io_word_done c=%0d: got %b want %b", c, lsb_done, (c == 2)); end
      next_cycle();
    end
    n_checks++; if (wr_cnt != 1) begin n_fail++; $display("FAIL io_word_count: got %0d want 1", wr_cnt); end
  endtask

  task automatic test_flush();
    logic [31:0] exp_a;
    logic        exp_wr;
    logic [31:0] wd;
    int          wr_cnt;
    do_reset();
    wd = 32'h11223344;
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 0; c < 12; c++) begin
      if (c == 3) begin
        flush = 1'b1;
        lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h200; lsb_wdata = wd;
      end
      if (c == 4) begin flush = 1'b0; if_req = 1'b0; end
      if (c == 10) lsb_req = 1'b0;
      @(negedge clk_in);
      exp_wr = (c >= 5 && c <= 8);
      exp_a  = exp_wr ? 32'h200 + 32'(c - 5) : (c >= 1 && c <= 3) ? 32'h10 + 32'(c - 1) : 32'h0;
      n_checks++; if (mem_a !== exp_a || mem_wr !== exp_wr) begin n_fail++; $display("FAIL flush_addr c=%0d: got %h/%b want %h/%b", c, mem_a, mem_wr, exp_a, exp_wr); end
      if (exp_wr) begin
        n_checks++; if (mem_dout !== wd[8*(c-5) +: 8]) begin n_fail++; $display("FAIL flush_dout c=%0d: got %h want %h", c, mem_dout, wd[8*(c-5) +: 8]); end
      end
      n_checks++; if (if_done !== 1'b0 || lsb_done !== (c == 9)) begin n_fail++; $display("FAIL flush_done c=%0d: got if=%b lsb=%b", c, if_done, lsb_done); end
      next_cycle();
    end
    // A store is not aborted by flush
    do_reset();
    wr_cnt = 0;
    lsb_req = 1'b1; lsb_wr = 1'b1; lsb_size = 2'd2; lsb_addr = 32'h300; lsb_wdata = 32'hCAFEF00D;
    for (int c = 0; c < 8; c++) begin
      flush = (c == 2);
      if (c == 6) lsb_req = 1'b0;
      @(negedge clk_in);
      if (mem_wr === 1'b1) wr_cnt++;
      n_checks++; if (lsb_done !== (c == 5)) begin n_fail++; $display("FAIL flush_store_done c=%0d: got %b want %b", c, lsb_done, (c == 5)); end
      next_cycle();
    end
    n_checks++; if (wr_cnt != 4) begin n_fail++; $display("FAIL flush_store_bytes: got %0d want 4", wr_cnt); end
  endtask

  task automatic test_rdy_stall();
    logic [31:0] exp_a;
    do_reset();
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd1; lsb_addr = 32'h20;
    for (int c = 0; c < 9; c++) begin
      if (c == 2) rdy_in = 1'b0;
      if (c == 5) rdy_in = 1'b1;
      if (c == 8) lsb_req = 1'b0;
      @(negedge clk_in);
      exp_a = (c == 1) ? 32'h20 : (c == 5) ? 32'h21 : 32'h0;
      n_checks++; if (mem_a !== exp_a || mem_wr !== 1'b0) begin n_fail++; $display("FAIL stall_addr c=%0d: got %h/%b want %h/0", c, mem_a, mem_wr, exp_a); end
      n_checks++; if (lsb_done !== (c == 7)) begin n_fail++; $display("FAIL stall_done c=%0d: got %b want %b", c, lsb_done, (c == 7)); end
      if (c == 7) begin
        n_checks++; if (lsb_rdata !== 32'h00005AA5) begin n_fail++; $display("FAIL stall_rdata: got %h want 00005aa5", lsb_rdata); end
      end
      next_cycle();
    end
  endtask

  // Follows test_rdy_stall without a reset so lsb_rdata starts non-zero
  task automatic test_reset_mid();
    logic [31:0] exp_a;
    lsb_req = 1'b1; lsb_wr = 1'b0; lsb_size = 2'd2; lsb_addr = 32'h20;
    for (int c = 0; c < 11; c++) begin
      if (c == 2) rst_in = 1'b1;
      if (c == 3) begin rst_in = 1'b0; lsb_req = 1'b0; end
      if (c == 5) begin lsb_req = 1'b1; lsb_size = 2'd1; lsb_addr = 32'h22; end
      if (c == 10) lsb_req = 1'b0;
      @(negedge clk_in);
      if (c == 0) begin
        n_checks++; if (lsb_rdata !== 32'h00005AA5) begin n_fail++; $display("FAIL rst_mid_before: got %h want 00005aa5", lsb_rdata); end
      end
      exp_a = (c == 1) ? 32'h20 : (c == 2) ? 32'h21 : (c == 6) ? 32'h22 : (c == 7) ? 32'h23 : 32'h0;
      n_checks++; if (mem_a !== exp_a || mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_addr c=%0d: got %h/%b want %h/0", c, mem_a, mem_wr, exp_a); end
      if (c == 3) begin
        n_checks++; if (mem_dout !== 8'h0 || if_done !== 1'b0 || lsb_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctrl: got %h %b %b want 00 0 0", mem_dout, if_done, lsb_done); end
        n_checks++; if (lsb_rdata !== 32'h0 || if_data !== 32'h0) begin n_fail++; $display("FAIL rst_mid_data: got %h %h want 0 0", lsb_rdata, if_data); end
      end
      n_checks++; if (lsb_done !== (c == 9)) begin n_fail++; $display("FAIL rst_mid_done c=%0d: got %b want %b", c, lsb_done, (c == 9)); end
      if (c == 9) begin
        n_checks++; if (lsb_rdata !== 32'h00006677) begin n_fail++; $display("FAIL rst_mid_rdata: got %h want 00006677", lsb_rdata); end
      end
      next_cycle();
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16'h10] = 8'h13; mem[16'h11] = 8'h05; mem[16'h12] = 8'h00; mem[16'h13] = 8'h00;
    mem[16'h20] = 8'hA5; mem[16'h21] = 8'h5A; mem[16'h22] = 8'h77; mem[16'h23] = 8'h66;
    mem[16'h40] = 8'h12; mem[16'h41] = 8'h34; mem[16'h42] = 8'h56; mem[16'h43] = 8'h78;
    clear_inputs();
    rst_in = 1'b1;
    test_reset();
    test_if_read();
    test_back_to_back();
    test_io_write();
    test_flush();
    test_rdy_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
